// File: rtl/serial_addsub_8bit.sv
// Bit-serial adder/subtractor.
// A single full-adder cell is reused over WIDTH clock cycles, LSB first.
// Subtraction is performed as in1 + ~in2 + ~c_in, so c_out = 0 flags a borrow.
// A start/busy/done handshake lets a datapath controller sequence operations.
// The result register changes only on the final bit-cycle, never mid-operation.

module serial_addsub_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             c_in,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Full-adder sum bit.
    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    // Full-adder carry (majority of the three inputs).
    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] res_sr_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             c_out_r;
    logic             ovf_r;

    logic             bit_s;
    logic             carry_nxt_s;
    logic             last_s;
    logic             accept_s;

    // Bit-slice arithmetic, last-bit detection and start acceptance.
    always_comb begin
        bit_s       = fa_sum(a_sr_r[0], b_sr_r[0], carry_r);
        carry_nxt_s = fa_carry(a_sr_r[0], b_sr_r[0], carry_r);
        last_s      = 1'b0;
        accept_s    = 1'b0;
        if (cnt_r == CW'(WIDTH - 1)) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
        case (state_r)
            ST_IDLE: accept_s = start;
            ST_DONE: accept_s = start;
            ST_RUN:  accept_s = 1'b0;
            default: accept_s = 1'b0;
        endcase
    end

    // Controller FSM and datapath registers with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            a_sr_r   <= '0;
            b_sr_r   <= '0;
            res_sr_r <= '0;
            cnt_r    <= '0;
            carry_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            sum_r    <= '0;
            c_out_r  <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        // Capture operands; subtraction pre-inverts B and the borrow.
                        a_sr_r  <= in1;
                        b_sr_r  <= sub ? ~in2 : in2;
                        carry_r <= sub ? ~c_in : c_in;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
                    b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
                    res_sr_r <= {bit_s, res_sr_r[WIDTH-1:1]};
                    carry_r  <= carry_nxt_s;
                    cnt_r    <= cnt_r + CW'(1);
                    if (last_s) begin
                        // carry_r here is the carry into the MSB slice.
                        sum_r   <= {bit_s, res_sr_r[WIDTH-1:1]};
                        c_out_r <= carry_nxt_s;
                        ovf_r   <= carry_r ^ carry_nxt_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign sum      = sum_r;
    assign c_out    = c_out_r;
    assign overflow = ovf_r;

endmodule

// File: tb/tb_serial_addsub_8bit.sv
// Directed and random checks for the bit-serial adder/subtractor.

module tb_serial_addsub_8bit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic       c_in;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       c_out;
    logic       overflow;

    int n_vec;
    int n_err;

    serial_addsub_8bit #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .c_in     (c_in),
        .in1      (in1),
        .in2      (in2),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       s;
        logic       ci;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] e_sum;
        logic       e_c;
        logic       e_v;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: {c_out, overflow, sum} from plain integer arithmetic and the sign rule.
    function automatic logic [9:0] model(input logic s, input logic ci,
                                         input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        logic [7:0] bb;
        logic       cc;
        logic       v;
        bb = s ? ~b : b;
        cc = s ? ~ci : ci;
        r  = {1'b0, a} + {1'b0, bb} + {8'b0, cc};
        if (s) v = (a[7] != b[7]) && (r[7] != a[7]);
        else   v = (a[7] == b[7]) && (r[7] != a[7]);
        return {r[8], v, r[7:0]};
    endfunction

    // One operation: capture, scramble inputs afterwards, wait (bounded) for done.
    task automatic run_op(input logic s, input logic ci, input logic [7:0] a, input logic [7:0] b,
                          output logic [9:0] res, output int lat, output int bcnt,
                          output logic hold_ok, output logic ok);
        logic [7:0] prev;
        @(negedge clk);
        sub = s; c_in = ci; in1 = a; in2 = b; start = 1'b1;
        prev = sum;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; sub = ~s; c_in = ~ci; in1 = ~a; in2 = ~b;
        lat = 1; bcnt = 0; hold_ok = 1'b1; ok = 1'b0; res = '0;
        for (int i = 0; i < 40; i++) begin
            if (busy) bcnt++;
            if (done) begin
                ok  = 1'b1;
                res = {c_out, overflow, sum};
                break;
            end
            if (sum !== prev) hold_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    vec_t       vecs[12];
    logic [9:0] res;
    logic [9:0] exp_r;
    int         lat;
    int         bcnt;
    logic       hold_ok;
    logic       ok;

    initial begin
        n_vec = 0; n_err = 0;
        start = 1'b0; sub = 1'b0; c_in = 1'b0; in1 = 8'd0; in2 = 8'd0;

        vecs[0]  = '{1'b0, 1'b0, 8'd102, 8'd103, 8'd205, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 8'd203, 8'd2,   8'd206, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'd141, 8'd114, 8'd255, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'd140, 8'd116, 8'd0,   1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'd139, 8'd117, 8'd1,   1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 8'd5,   8'd7,   8'd254, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 8'd128, 8'd1,   8'd127, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 8'd255, 8'd255, 8'd255, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 8'd0,   8'd0,   8'd0,   1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 8'd0,   8'd0,   8'd255, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'd127, 8'd1,   8'd128, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 8'd100, 8'd30,  8'd69,  1'b1, 1'b0};

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {20'd0, busy, done, c_out, overflow, sum}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].s, vecs[i].ci, vecs[i].a, vecs[i].b, res, lat, bcnt, hold_ok, ok);
            chk($sformatf("vec%0d_done_seen", i), {31'd0, ok}, 32'd1);
            chk($sformatf("vec%0d_result", i), {22'd0, res},
                {22'd0, vecs[i].e_c, vecs[i].e_v, vecs[i].e_sum});
            chk($sformatf("vec%0d_latency", i), lat, 32'd9);
            chk($sformatf("vec%0d_busy_cycles", i), bcnt, 32'd8);
            chk($sformatf("vec%0d_sum_hold", i), {31'd0, hold_ok}, 32'd1);
        end

        // Back-to-back: start held high, inputs scrambled while busy
        begin
            logic [7:0] ba[3];
            logic [7:0] bb[3];
            logic       bs[3];
            int k;
            int cyc;
            int last;
            ba[0] = 8'd1;   bb[0] = 8'd2;   bs[0] = 1'b0;
            ba[1] = 8'd50;  bb[1] = 8'd20;  bs[1] = 1'b1;
            ba[2] = 8'd200; bb[2] = 8'd100; bs[2] = 1'b0;
            @(negedge clk);
            in1 = ba[0]; in2 = bb[0]; sub = bs[0]; c_in = 1'b0; start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            k = 0; cyc = 1; last = 0;
            for (int t = 0; t < 60; t++) begin
                if (k >= 3) break;
                if (done) begin
                    exp_r = model(bs[k], 1'b0, ba[k], bb[k]);
                    chk($sformatf("b2b%0d_result", k), {22'd0, c_out, overflow, sum}, {22'd0, exp_r});
                    if (k > 0) chk($sformatf("b2b%0d_period", k), cyc - last, 32'd9);
                    last = cyc;
                    k++;
                    if (k < 3) begin
                        in1 = ba[k]; in2 = bb[k]; sub = bs[k]; c_in = 1'b0;
                    end else begin
                        start = 1'b0;
                    end
                end else if (busy) begin
                    in1 = 8'($urandom); in2 = 8'($urandom);
                    sub = 1'($urandom); c_in = 1'($urandom);
                end
                @(negedge clk);
                cyc++;
            end
            start = 1'b0;
            chk("b2b_ops_completed", k, 32'd3);
        end

        // Start pulse mid-RUN with different operands is ignored
        repeat (2) @(negedge clk);
        sub = 1'b1; c_in = 1'b0; in1 = 8'd128; in2 = 8'd1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        sub = 1'b0; c_in = 1'b1; in1 = 8'd200; in2 = 8'd50; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("midrun_done_seen", {31'd0, ok}, 32'd1);
        chk("midrun_result", {22'd0, c_out, overflow, sum}, {22'd0, 1'b1, 1'b1, 8'd127});
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);

        // Asynchronous reset at bit-cycle 4 of an add
        @(negedge clk);
        sub = 1'b0; c_in = 1'b0; in1 = 8'd50; in2 = 8'd60; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {20'd0, busy, done, c_out, overflow, sum}, 32'd0);
        ok = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) ok = 1'b1;
        end
        chk("no_done_after_abort", {31'd0, ok}, 32'd0);
        rst_n = 1'b1;
        run_op(1'b0, 1'b1, 8'd255, 8'd255, res, lat, bcnt, hold_ok, ok);
        chk("post_reset_done_seen", {31'd0, ok}, 32'd1);
        chk("post_reset_max_add", {22'd0, res}, {22'd0, 1'b1, 1'b0, 8'd255});

        // Random operations against the behavioural model
        for (int i = 0; i < 1000; i++) begin
            logic       rs;
            logic       rc;
            logic [7:0] ra;
            logic [7:0] rb;
            rs = 1'($urandom); rc = 1'($urandom);
            ra = 8'($urandom); rb = 8'($urandom);
            run_op(rs, rc, ra, rb, res, lat, bcnt, hold_ok, ok);
            exp_r = model(rs, rc, ra, rb);
            chk($sformatf("rand%0d s=%0b ci=%0b a=%0d b=%0d", i, rs, rc, ra, rb),
                {21'd0, ok, res}, {21'd0, 1'b1, exp_r});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
